typer_scheduler: RTL and testbench
==================================

// Module: typer_scheduler
// PURPOSE
//  Sequences the character typer for the text console below the playfield (pixel rows 270..479).
//  Accepts ASCII codes through a valid/ready port and buffers them in a small FIFO.
//  Tracks the text cursor, interprets control codes (newline, backspace, clear) and issues
//  one typer request per glyph using the typer's start/finished handshake.
// PARAMETERS
//  TEXT_COLS   32  character columns (640 px / 20 px)
//  TEXT_ROWS   7   character rows (210 px / 30 px)
//  FIFO_DEPTH  4   input FIFO entries; power of two
//  ACK_TIMEOUT 15  cycles to wait for the typer to drop finished before re-issuing start
// PORTS
//  clock                    in   1  system clock; all logic on posedge
//  resetn                   in   1  asynchronous, active-low reset
//  char_in                  in   8  ASCII code from keyboard/game logic
//  char_valid               in   1  char_in valid
//  char_ready               out  1  FIFO not full; a char is accepted when valid&ready
//  finished_saving_char     in   1  typer idle flag (high = idle)
//  start_writing_character  out  1  typer start request
//  row_num                  out  8  typer target row
//  col_num                  out  8  typer target column
//  character_input          out  8  glyph code to the typer
//  cursor_row               out  8  current cursor row
//  cursor_col               out  8  current cursor column
//  sched_busy               out  1  high while not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset: state IDLE. FIFO empty. Cursor 0,0. start_writing_character=0.
//   row_num/col_num/character_input=0. char_ready=1. sched_busy=0.
//  FIFO: push on char_valid&char_ready. Pop only in IDLE. Push and pop may coincide when full.
//  States:
//   IDLE: if FIFO non-empty and finished_saving_char=1, pop the head and decode it:
//     0x0A newline: cursor col:=0, row:=row+1 (TEXT_ROWS-1 wraps to 0); no typer access; stay IDLE.
//     0x08 backspace: if cursor is 0,0 do nothing. Else step the cursor back one cell
//       (col 0 -> col TEXT_COLS-1 of the previous row) and go to ISSUE with glyph 0x20 at the new cell.
//       The cursor does not advance afterwards.
//     0x0C clear: set clr_row=0, clr_col=0; go to CLEAR_ISSUE.
//     any other code: go to ISSUE with the code at the cursor. The cursor advances after DONE.
//   ISSUE: drive row_num/col_num/character_input and assert start_writing_character; go to WAIT_ACK.
//     The outputs stay stable until WAIT_DONE.
//   WAIT_ACK: hold start until finished_saving_char=0, then deassert start and go to WAIT_DONE.
//     If ACK_TIMEOUT cycles pass with no drop, deassert start for 1 cycle and return to ISSUE.
//   WAIT_DONE: on finished_saving_char=1, advance the cursor for a printable char:
//     col+1; at TEXT_COLS-1 col:=0, row+1; at the last cell wrap to 0,0. Go to IDLE.
//   CLEAR_ISSUE/CLEAR_ACK/CLEAR_DONE: same handshake with glyph 0x20 at clr_row,clr_col.
//     Step row-major. After cell (TEXT_ROWS-1,TEXT_COLS-1), set cursor 0,0 and go to IDLE.
//     The FIFO keeps accepting during a clear.
//  start_writing_character is registered and held at least 2 cycles. The typer samples on negedge.
//  Latency: printable char with an idle typer -> start high 2 cycles after the push (FIFO reg + IDLE).
//  Arithmetic: cursor counters are 8 bit and compared with ==, never >. No value above the limit is produced.
//  Reset mid-operation: returns to reset state immediately. Start drops asynchronously. FIFO contents are lost.
// TESTING
//  1. Push 'A'(0x41) at 0,0. Typer model finishes in 600 cycles.
//     -> one start, row=0 col=0 char=0x41; cursor 0,1 afterwards.
//  2. Push 33 printable chars. -> 33rd written at row 1 col 0; cursor 1,1.
//  3. Cursor 0,5; push 0x08. -> space written at 0,4; cursor 0,4. Repeat at 0,0 -> no start.
//  4. Cursor 3,7; push 0x0A. -> cursor 4,0, no start. At row 6 -> wraps to 0,0.
//  5. Push 0x0C then 'B'. -> 224 space writes in row-major order, then 'B' at 0,0.
//     char_ready=0 after 4 pushes while clearing.
//  6. Typer never drops finished. -> start re-issued every ACK_TIMEOUT+1 cycles.
//     Assert resetn=0 mid-wait -> start=0, cursor 0,0, char_ready=1.

Source files
------------

// File: rtl/typer_scheduler.sv
// Console text scheduler: buffers ASCII codes, tracks the cursor, decodes control codes
// and drives the character typer through its start/finished handshake.
module typer_scheduler #(
  parameter int TEXT_COLS   = 32,
  parameter int TEXT_ROWS   = 7,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       finished_saving_char,
  output logic       start_writing_character,
  output logic [7:0] row_num,
  output logic [7:0] col_num,
  output logic [7:0] character_input,
  output logic [7:0] cursor_row,
  output logic [7:0] cursor_col,
  output logic       sched_busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [7:0] LAST_COL = 8'(TEXT_COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(TEXT_ROWS - 1);
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_CLR   = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_CLR_ISSUE, S_CLR_ACK, S_CLR_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
  } cell_t;

  // Row-major step forward; the last cell wraps to the origin.
  function automatic cell_t cell_next(input cell_t c);
    cell_t n;
    n = c;
    if (c.col == LAST_COL) begin
      n.col = '0;
      n.row = (c.row == LAST_ROW) ? 8'd0 : c.row + 8'd1;
    end else begin
      n.col = c.col + 8'd1;
    end
    return n;
  endfunction

  // Row-major step back; callers guarantee the cell is not the origin.
  function automatic cell_t cell_prev(input cell_t c);
    cell_t n;
    n = c;
    if (c.col == 8'd0) begin
      n.col = LAST_COL;
      n.row = c.row - 8'd1;
    end else begin
      n.col = c.col - 8'd1;
    end
    return n;
  endfunction

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  cell_t              cur_q, cur_d, clr_q, clr_d, tgt_q, tgt_d;
  logic [7:0]         glyph_q, glyph_d;
  logic               adv_q, adv_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               start_q, start_d;
  logic [7:0]         row_num_q, row_num_d, col_num_q, col_num_d, char_q, char_d;
  logic [7:0]         fifo_mem [FIFO_DEPTH];

  logic       fifo_empty, fifo_full, push, pop;
  logic [7:0] head;
  cell_t      cur_next, cur_prev, clr_next;

  assign head       = fifo_mem[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = (state_q == S_IDLE) && !fifo_empty && finished_saving_char;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a char.
  assign char_ready = !fifo_full || pop;
  assign push       = char_valid && char_ready;
  assign cur_next   = cell_next(cur_q);
  assign cur_prev   = cell_prev(cur_q);
  assign clr_next   = cell_next(clr_q);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    cur_d     = cur_q;
    clr_d     = clr_q;
    tgt_d     = tgt_q;
    glyph_d   = glyph_q;
    adv_d     = adv_q;
    tmr_d     = tmr_q;
    start_d   = start_q;
    row_num_d = row_num_q;
    col_num_d = col_num_q;
    char_d    = char_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          case (head)
            CH_NL: begin
              cur_d.col = '0;
              cur_d.row = (cur_q.row == LAST_ROW) ? 8'd0 : cur_q.row + 8'd1;
            end
            CH_BS: begin
              if (cur_q.row != 8'd0 || cur_q.col != 8'd0) begin
                cur_d   = cur_prev;
                tgt_d   = cur_prev;
                glyph_d = CH_SPACE;
                adv_d   = 1'b0;
                state_d = S_ISSUE;
              end
            end
            CH_CLR: begin
              clr_d   = '0;
              state_d = S_CLR_ISSUE;
            end
            default: begin
              tgt_d   = cur_q;
              glyph_d = head;
              adv_d   = 1'b1;
              state_d = S_ISSUE;
            end
          endcase
        end
      end
      S_ISSUE: begin
        start_d   = 1'b1;
        row_num_d = tgt_q.row;
        col_num_d = tgt_q.col;
        char_d    = glyph_q;
        tmr_d     = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK, S_CLR_ACK: begin
        if (!finished_saving_char) begin
          start_d = 1'b0;
          state_d = (state_q == S_WAIT_ACK) ? S_WAIT_DONE : S_CLR_DONE;
        end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          // Typer missed the request: drop start for one cycle and re-issue.
          start_d = 1'b0;
          state_d = (state_q == S_WAIT_ACK) ? S_ISSUE : S_CLR_ISSUE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (finished_saving_char) begin
          if (adv_q) cur_d = cur_next;
          state_d = S_IDLE;
        end
      end
      S_CLR_ISSUE: begin
        start_d   = 1'b1;
        row_num_d = clr_q.row;
        col_num_d = clr_q.col;
        char_d    = CH_SPACE;
        tmr_d     = '0;
        state_d   = S_CLR_ACK;
      end
      S_CLR_DONE: begin
        if (finished_saving_char) begin
          if (clr_q.row == LAST_ROW && clr_q.col == LAST_COL) begin
            cur_d   = '0;
            state_d = S_IDLE;
          end else begin
            clr_d   = clr_next;
            state_d = S_CLR_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cur_q     <= '0;
      clr_q     <= '0;
      adv_q     <= 1'b0;
      tmr_q     <= '0;
      start_q   <= 1'b0;
      row_num_q <= '0;
      col_num_q <= '0;
      char_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cur_q     <= cur_d;
      clr_q     <= clr_d;
      adv_q     <= adv_d;
      tmr_q     <= tmr_d;
      start_q   <= start_d;
      row_num_q <= row_num_d;
      col_num_q <= col_num_d;
      char_q    <= char_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= char_in;
    tgt_q   <= tgt_d;
    glyph_q <= glyph_d;
  end

  assign start_writing_character = start_q;
  assign row_num         = row_num_q;
  assign col_num         = col_num_q;
  assign character_input = char_q;
  assign cursor_row      = cur_q.row;
  assign cursor_col      = cur_q.col;
  assign sched_busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_typer_scheduler.sv
// Randomised scoreboard bench for typer_scheduler with a behavioural typer and cursor model.
module tb_typer_scheduler;
  localparam int COLS = 32;
  localparam int ROWS = 7;
  localparam int TMO  = 15;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       finished = 1'b1;
  logic       start;
  logic [7:0] row_num, col_num, character_input, cursor_row, cursor_col;
  logic       sched_busy;

  typer_scheduler #(.TEXT_COLS(COLS), .TEXT_ROWS(ROWS), .FIFO_DEPTH(4), .ACK_TIMEOUT(TMO)) dut (
    .clock(clock), .resetn(resetn), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .finished_saving_char(finished),
    .start_writing_character(start), .row_num(row_num), .col_num(col_num),
    .character_input(character_input), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .sched_busy(sched_busy));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_r = 0;
  int model_c = 0;
  int n_writes = 0;
  int typer_busy = 3;
  bit typer_rand = 1'b1;
  bit typer_stuck = 1'b0;
  bit typer_idle = 1'b1;
  logic [23:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: cursor as a linear cell index, one expected typer write per visible glyph.
  function automatic void model_apply(input logic [7:0] ch);
    int idx;
    case (ch)
      8'h0A: begin model_c = 0; model_r = (model_r + 1) % ROWS; end
      8'h08: begin
        if (model_r != 0 || model_c != 0) begin
          idx = model_r * COLS + model_c - 1;
          model_r = idx / COLS;
          model_c = idx % COLS;
          exp_q.push_back({8'(model_r), 8'(model_c), 8'h20});
        end
      end
      8'h0C: begin
        for (int i = 0; i < ROWS * COLS; i++) exp_q.push_back({8'(i / COLS), 8'(i % COLS), 8'h20});
        model_r = 0;
        model_c = 0;
      end
      default: begin
        exp_q.push_back({8'(model_r), 8'(model_c), ch});
        idx = (model_r * COLS + model_c + 1) % (ROWS * COLS);
        model_r = idx / COLS;
        model_c = idx % COLS;
      end
    endcase
  endfunction

  // Typer model and output monitor: each accepted start is one write, checked against the queue.
  initial begin : typer_monitor
    logic [23:0] e;
    int d;
    int b;
    forever begin
      @(negedge clock);
      if (resetn && !typer_stuck && typer_idle && start) begin
        typer_idle = 1'b0;
        n_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("write_row", row_num, e[23:16]);
          check("write_col", col_num, e[15:8]);
          check("write_char", character_input, e[7:0]);
        end
        d = typer_rand ? $urandom_range(0, 3) : 0;
        b = typer_rand ? $urandom_range(2, 8) : typer_busy;
        repeat (d) @(posedge clock);
        @(posedge clock);
        #1 finished = 1'b0;
        repeat (b) @(posedge clock);
        #1 finished = 1'b1;
        typer_idle = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #800000;
    errors++;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [7:0] ch, input bit apply);
    int k = 0;
    char_in = ch;
    char_valid = 1'b1;
    @(negedge clock);
    while (!char_ready && k < 5000) begin
      @(negedge clock);
      k++;
    end
    if (!char_ready) check("push_timeout", 0, 1);
    @(posedge clock);
    #1 char_valid = 1'b0;
    if (char_ready === 1'b1 || k < 5000) begin
      if (apply) model_apply(ch);
    end
  endtask

  function automatic bit drained();
    return !sched_busy && exp_q.size() == 0 && typer_idle && finished;
  endfunction

  task automatic wait_drain(input int budget);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!drained() && k < budget);
    if (!drained()) check("drain_timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, cursor_row, r);
    check({name, "_col"}, cursor_col, c);
    check({name, "_model_row"}, cursor_row, model_r);
    check({name, "_model_col"}, cursor_col, model_c);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_q.delete();
    model_r = 0;
    model_c = 0;
    typer_stuck = 1'b0;
    finished = 1'b1;
    typer_idle = 1'b1;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(8'h21, 8'h7E));
  endfunction

  initial begin : stimulus
    int w;
    int hi;
    logic prev;
    int rises[$];
    int r;

    repeat (3) @(posedge clock);
    #1;
    check("rst_start", start, 0);
    check("rst_row_num", row_num, 0);
    check("rst_col_num", col_num, 0);
    check("rst_char", character_input, 0);
    check("rst_ready", char_ready, 1);
    check("rst_busy", sched_busy, 0);
    check_cursor("rst_cursor", 0, 0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Single 'A' with a slow typer, including push-to-start latency.
    typer_rand = 1'b0;
    typer_busy = 600;
    push(8'h41, 1'b1);
    @(negedge clock);
    @(negedge clock);
    check("latency_early", start, 0);
    @(negedge clock);
    check("latency_start", start, 1);
    wait_drain(5000);
    check("single_write_count", n_writes, 1);
    check_cursor("after_A", 0, 1);

    // 33 printable chars wrap into row 1.
    typer_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 33; i++) push(rand_print(), 1'b1);
    wait_drain(5000);
    check_cursor("after_33", 1, 1);

    // Backspace mid-row and at the origin.
    do_reset();
    for (int i = 0; i < 5; i++) push(rand_print(), 1'b1);
    wait_drain(2000);
    check_cursor("before_bs", 0, 5);
    push(8'h08, 1'b1);
    wait_drain(2000);
    check_cursor("after_bs", 0, 4);
    do_reset();
    w = n_writes;
    push(8'h08, 1'b1);
    wait_drain(2000);
    repeat (20) @(posedge clock);
    #1;
    check("bs_origin_no_start", n_writes, w);
    check_cursor("bs_origin", 0, 0);

    // Newlines, including the bottom-row wrap.
    do_reset();
    for (int i = 0; i < 3; i++) push(8'h0A, 1'b1);
    for (int i = 0; i < 7; i++) push(rand_print(), 1'b1);
    wait_drain(2000);
    check_cursor("at_3_7", 3, 7);
    w = n_writes;
    push(8'h0A, 1'b1);
    wait_drain(2000);
    check_cursor("nl_4_0", 4, 0);
    check("nl_no_start", n_writes, w);
    push(8'h0A, 1'b1);
    push(8'h0A, 1'b1);
    wait_drain(2000);
    check_cursor("nl_6_0", 6, 0);
    push(8'h0A, 1'b1);
    wait_drain(2000);
    check_cursor("nl_wrap", 0, 0);

    // Clear screen; FIFO fills while the clear runs.
    do_reset();
    push(8'h51, 1'b1);
    push(8'h52, 1'b1);
    wait_drain(2000);
    w = n_writes;
    push(8'h0C, 1'b1);
    r = 0;
    while (n_writes == w && r < 200) begin
      @(negedge clock);
      r++;
    end
    check("clear_started", (n_writes > w) ? 1 : 0, 1);
    @(posedge clock);
    #1;
    push(8'h42, 1'b1);
    for (int i = 0; i < 3; i++) push(rand_print(), 1'b1);
    @(negedge clock);
    check("ready_full_clear", char_ready, 0);
    check("busy_clear", sched_busy, 1);
    @(posedge clock);
    #1;
    wait_drain(30000);
    check("clear_write_count", n_writes - w, ROWS * COLS + 4);
    check_cursor("after_clear", 0, 4);

    // Randomised mix of printable, newline and backspace codes.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) push(8'h0A, 1'b1);
      else if (r < 22) push(8'h08, 1'b1);
      else push(rand_print(), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    wait_drain(10000);
    check_cursor("random_end", model_r, model_c);

    // Typer never acknowledges: start re-issued periodically, then reset mid-wait.
    do_reset();
    typer_stuck = 1'b1;
    push(8'h43, 1'b0);
    prev = 1'b0;
    hi = 0;
    for (int k = 0; k < 200 && rises.size() < 3; k++) begin
      @(negedge clock);
      if (start && !prev) rises.push_back(cyc);
      else if (start && rises.size() == 1) hi++;
      prev = start;
    end
    if (rises.size() < 3) begin
      check("reissue_seen", rises.size(), 3);
    end else begin
      check("reissue_period1", rises[1] - rises[0], TMO + 1);
      check("reissue_period2", rises[2] - rises[1], TMO + 1);
      check("start_high_cycles", hi + 1, TMO);
    end
    r = 0;
    while (!start && r < 50) begin
      @(negedge clock);
      r++;
    end
    resetn = 1'b0;
    #1;
    check("midreset_start", start, 0);
    check("midreset_ready", char_ready, 1);
    check("midreset_busy", sched_busy, 0);
    exp_q.delete();
    model_r = 0;
    model_c = 0;
    check_cursor("midreset", 0, 0);
    typer_stuck = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    w = n_writes;
    push(8'h5A, 1'b1);
    wait_drain(2000);
    check("post_reset_one_write", n_writes - w, 1);
    check_cursor("post_reset", 0, 1);

    check("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
